stim_seq: RTL and testbench

Parameterised serial stimulus sequencer sitting directly upstream of the generate-selected consumer modules in the diagnostic benches. On a start request it produces a reproducible serial bit stream `a`. Word content comes from a counter or an LFSR, selected at elaboration by a generate branch on `MODE`. Delivery uses a valid/ready handshake, with a one-cycle completion pulse at the end of the run. It gives benches deterministic, parameter-dependent toggle activity on the signal the consumers sample.

---
 rtl/stim_seq_pkg.sv | 20 ++
 rtl/stim_seq_src.sv | 48 ++++
 rtl/stim_seq.sv | 131 +++++++++++++
 tb/tb_stim_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg: shared definitions for the serial stimulus sequencer.
//   state_t      - FSM state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//   MODE_*       - word source selection values
//   DEFAULT_*    - default seed and right-shift Galois feedback mask
package stim_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MODE_COUNTER = 0;
    localparam int MODE_LFSR    = 1;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
    localparam logic [31:0] DEFAULT_TAPS = 32'h0000_00B8;

endpackage

// File: rtl/stim_seq_src.sv
// stim_seq_src: word source for stim_seq.
//   clock   in   sole clock
//   reset   in   synchronous active-high reset, loads SEED
//   reload  in   load SEED (held while the sequencer is idle)
//   advance in   step to the next word
//   word    out  current source word
// MODE selects an incrementing counter or a right-shift Galois LFSR.
module stim_seq_src
    import stim_seq_pkg::*;
#(
    parameter int          MODE  = MODE_COUNTER,
    parameter int          WIDTH = 8,
    parameter logic [31:0] SEED  = DEFAULT_SEED,
    parameter logic [31:0] TAPS  = DEFAULT_TAPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reload,
    input  logic             advance,
    output logic [WIDTH-1:0] word
);

    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    generate
        if (MODE == MODE_COUNTER) begin : g_counter
            // Wraps modulo 2^WIDTH without any special handling.
            always_comb word_d = word_q + 1'b1;
        end else begin : g_lfsr
            always_comb word_d = (word_q >> 1) ^ (word_q[0] ? TAPS_W : '0);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset || reload) begin
            word_q <= SEED_W;
        end else if (advance) begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/stim_seq.sv
// stim_seq: serial stimulus sequencer. On start, emits NWORDS words of
// WIDTH bits, MSB first, over a valid/ready handshake, then pulses done.
//   clock    in   sole clock
//   reset    in   synchronous active-high reset
//   start    in   run request, honoured only in IDLE
//   a        out  serial data bit
//   a_valid  out  a holds a valid bit
//   a_ready  in   consumer accepts a on this edge
//   busy     out  high whenever not idle
//   done     out  one-cycle pulse after the last bit is accepted
//
// state | meaning
// IDLE  | waiting for start, source held at SEED
// LOAD  | copy source word into shift register, advance source
// SHIFT | present MSB, shift on each accepted beat
// DONE  | one-cycle completion pulse
module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int          MODE   = MODE_COUNTER,
    parameter int          WIDTH  = 8,
    parameter int          NWORDS = 2,
    parameter logic [31:0] SEED   = DEFAULT_SEED,
    parameter logic [31:0] TAPS   = DEFAULT_TAPS
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic a,
    output logic a_valid,
    input  logic a_ready,
    output logic busy,
    output logic done
);

    localparam int              BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [7:0]      LAST_WORD = 8'(NWORDS - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [7:0]       word_cnt_q;
    logic             a_q;
    logic             a_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] src_word;
    logic             src_reload;
    logic             src_advance;

    assign src_reload  = (state_q == ST_IDLE);
    assign src_advance = (state_q == ST_LOAD);

    stim_seq_src #(
        .MODE  (MODE),
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_src (
        .clock   (clock),
        .reset   (reset),
        .reload  (src_reload),
        .advance (src_advance),
        .word    (src_word)
    );

    // Outputs are registered alongside the state transition so that each
    // output already reflects the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            a_q        <= 1'b0;
            a_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    word_cnt_q <= '0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_q   <= src_word;
                    bit_cnt_q <= '0;
                    a_q       <= src_word[WIDTH-1];
                    a_valid_q <= 1'b1;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (a_ready) begin
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            a_q       <= 1'b0;
                            a_valid_q <= 1'b0;
                            if (word_cnt_q == LAST_WORD) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                                state_q    <= ST_LOAD;
                            end
                        end else begin
                            a_q <= shift_q[WIDTH-2];
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stim_seq.sv
// Testbench for stim_seq: three instances (counter A5, LFSR 01/B8, counter
// wrap FF) are driven with directed and randomised a_ready patterns and
// compared against a word-level reference model.
module tb_stim_seq;

    logic       clk;
    logic       reset;
    logic [2:0] start_s;
    logic [2:0] ready_s;
    logic [2:0] a_o;
    logic [2:0] av_o;
    logic [2:0] busy_o;
    logic [2:0] done_o;

    int n_pass  = 0;
    int n_total = 0;

    localparam int         MODE_T [3] = '{0, 1, 0};
    localparam logic [7:0] SEED_T [3] = '{8'hA5, 8'h01, 8'hFF};
    localparam int         N_T    [3] = '{2, 3, 2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_seq #(.MODE(0), .WIDTH(8), .NWORDS(2), .SEED(32'hA5), .TAPS(32'hB8)) u_cnt (
        .clock(clk), .reset(reset), .start(start_s[0]), .a(a_o[0]), .a_valid(av_o[0]),
        .a_ready(ready_s[0]), .busy(busy_o[0]), .done(done_o[0]));

    stim_seq #(.MODE(1), .WIDTH(8), .NWORDS(3), .SEED(32'h01), .TAPS(32'hB8)) u_lfsr (
        .clock(clk), .reset(reset), .start(start_s[1]), .a(a_o[1]), .a_valid(av_o[1]),
        .a_ready(ready_s[1]), .busy(busy_o[1]), .done(done_o[1]));

    stim_seq #(.MODE(0), .WIDTH(8), .NWORDS(2), .SEED(32'hFF), .TAPS(32'hB8)) u_wrap (
        .clock(clk), .reset(reset), .start(start_s[2]), .a(a_o[2]), .a_valid(av_o[2]),
        .a_ready(ready_s[2]), .busy(busy_o[2]), .done(done_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] next_word(input int mode, input logic [7:0] w);
        if (mode == 0) return w + 8'd1;
        return {1'b0, w[7:1]} ^ (w[0] ? 8'hB8 : 8'h00);
    endfunction

    // policy 0: ready always high; 1: random ready; 2: 3-cycle stall after
    // bit 3 of word 0; 3: ready high plus a stray start pulse mid-run.
    task automatic run_check(input int idx, input int policy, input string tag, output int done_cyc);
        logic [7:0] w;
        bit         exp_q[$];
        bit         got_q[$];
        int         cyc, stalls, gaps, hold;
        logic       prev_stall, prev_a;
        w = SEED_T[idx];
        for (int k = 0; k < N_T[idx]; k++) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
            w = next_word(MODE_T[idx], w);
        end
        @(negedge clk);
        start_s[idx] = 1'b1;
        ready_s[idx] = 1'b1;
        @(negedge clk);
        start_s[idx] = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy_o[idx]), 32'd1);
        check({tag, " valid_in_load"}, 32'(av_o[idx]), 32'd0);
        cyc = 1; stalls = 0; gaps = 0; hold = 0; prev_stall = 1'b0; prev_a = 1'b0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 400) begin
            if (done_o[idx]) begin
                done_cyc = cyc;
            end else begin
                case (policy)
                    1: ready_s[idx] = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (got_q.size() == 4 && hold < 3) begin
                            ready_s[idx] = 1'b0;
                            hold++;
                        end else begin
                            ready_s[idx] = 1'b1;
                        end
                    end
                    3: begin
                        ready_s[idx] = 1'b1;
                        start_s[idx] = (cyc == 4);
                    end
                    default: ready_s[idx] = 1'b1;
                endcase
                if (prev_stall) begin
                    check({tag, " stall_hold_a"}, 32'(a_o[idx]), 32'(prev_a));
                    check({tag, " stall_hold_valid"}, 32'(av_o[idx]), 32'd1);
                end
                check({tag, " busy_in_run"}, 32'(busy_o[idx]), 32'd1);
                if (!av_o[idx]) begin
                    check({tag, " a_zero_when_invalid"}, 32'(a_o[idx]), 32'd0);
                    gaps++;
                end else if (ready_s[idx]) begin
                    got_q.push_back(a_o[idx]);
                end else begin
                    stalls++;
                end
                prev_stall = av_o[idx] && !ready_s[idx];
                prev_a     = a_o[idx];
                @(negedge clk);
                cyc++;
            end
        end
        start_s[idx] = 1'b0;
        ready_s[idx] = 1'b1;
        if (done_cyc < 0) begin
            check({tag, " timeout_waiting_done"}, 32'd1, 32'd0);
        end else begin
            check({tag, " done_cycle"}, 32'(done_cyc), 32'(N_T[idx] * 9 + 1 + stalls));
            check({tag, " busy_with_done"}, 32'(busy_o[idx]), 32'd1);
            check({tag, " valid_with_done"}, 32'(av_o[idx]), 32'd0);
            check({tag, " load_gaps"}, 32'(gaps), 32'(N_T[idx]));
            check({tag, " bit_count"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("%s bit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (policy == 2) check({tag, " stall_cycles"}, 32'(stalls), 32'd3);
            @(negedge clk);
            check({tag, " done_single"}, 32'(done_o[idx]), 32'd0);
            check({tag, " busy_falls"}, 32'(busy_o[idx]), 32'd0);
            @(negedge clk);
            check({tag, " stays_idle"}, 32'(busy_o[idx] | av_o[idx]), 32'd0);
        end
    endtask

    initial begin
        int   dc;
        int   guard;
        logic [7:0] w0;

        // Reset held two cycles with start high: nothing may start.
        reset   = 1'b1;
        start_s = '1;
        ready_s = '1;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst%0d outputs", i),
                      {28'd0, a_o[i], av_o[i], busy_o[i], done_o[i]}, 32'd0);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        start_s = '0;
        for (int i = 0; i < 3; i++)
            check($sformatf("rst%0d busy_after_release", i), 32'(busy_o[i]), 32'd1);
        guard = 0;
        while (busy_o != 3'b000 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_after_reset", 32'(busy_o), 32'd0);

        run_check(0, 0, "cnt", dc);
        check("cnt done_at_19", 32'(dc), 32'd19);
        run_check(1, 0, "lfsr", dc);
        run_check(2, 0, "wrap", dc);
        run_check(0, 2, "bp", dc);
        check("bp done_at_22", 32'(dc), 32'd22);
        run_check(0, 3, "xstart", dc);
        for (int r = 0; r < 3; r++) begin
            run_check(0, 1, $sformatf("rnd_cnt%0d", r), dc);
            run_check(1, 1, $sformatf("rnd_lfsr%0d", r), dc);
            run_check(2, 1, $sformatf("rnd_wrap%0d", r), dc);
        end

        // Reset mid-word, then replay from SEED.
        w0 = SEED_T[0];
        @(negedge clk);
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid bit3_before_reset", 32'(a_o[0]), 32'(w0[4]));
        check("mid valid_before_reset", 32'(av_o[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid outputs_after_reset",
              {28'd0, a_o[0], av_o[0], busy_o[0], done_o[0]}, 32'd0);
        reset = 1'b0;
        run_check(0, 0, "replay", dc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
